// File: rtl/imem_loader.sv
// Byte-stream loader for the 64 x 32-bit instruction memory: assembles little-endian
// words, writes them one per WRITE cycle, verifies an XOR checksum and gates cpu_hold.
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          cpu_hold,
  output logic [2:0]    dbg_state_o
);

  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE
  } state_e;

  // Handshake: a byte transfers on a rising edge where rx_valid && rx_ready;
  // rx_ready depends only on the state register, never on rx_valid.
  state_e         state_q, state_d;
  logic [CW-1:0]  len_q, len_d;
  logic [CW-1:0]  count_q, count_d;
  logic [1:0]     idx_q, idx_d;
  logic [31:0]    word_q, word_d;
  logic [7:0]     xor_q, xor_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           hold_q, hold_d;
  logic           wr_en_q, wr_en_d;
  logic           csum_bad;

  assign csum_bad = (rx_data != xor_q);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    count_d  = count_q;
    idx_d    = idx_q;
    word_d   = word_q;
    xor_d    = xor_q;
    done_d   = done_q;
    err_d    = err_q;
    hold_d   = hold_q;
    wr_en_d  = 1'b0;
    rx_ready = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LEN;
          done_d  = 1'b0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
          count_d = '0;
          idx_d   = '0;
          xor_d   = '0;
        end
      end
      S_LEN: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          len_d = CW'(rx_data);
          if (rx_data == 8'd0 || rx_data > 8'(DEPTH)) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            hold_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          case (idx_q)
            2'd0:    word_d[7:0]   = rx_data;
            2'd1:    word_d[15:8]  = rx_data;
            2'd2:    word_d[23:16] = rx_data;
            default: word_d[31:24] = rx_data;
          endcase
          xor_d = xor_q ^ rx_data;
          if (idx_q == 2'd3) begin
            idx_d   = '0;
            wr_en_d = 1'b1;
            state_d = S_WRITE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_WRITE: begin
        count_d = count_q + CW'(1);
        state_d = (count_q + CW'(1) == len_q) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          err_d   = csum_bad;
          hold_d  = csum_bad;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      count_q <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      xor_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
      wr_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      xor_q   <= xor_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
      wr_en_q <= wr_en_d;
    end
  end

  // wr_en comes straight from a flop so the memory strobe cannot glitch.
  assign wr_en       = wr_en_q;
  assign wr_addr     = count_q[AW-1:0];
  assign wr_data     = word_q;
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = done_q;
  assign err         = err_q;
  assign cpu_hold    = hold_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader: a byte-list reference model predicts writes and
// session results into queues; a negedge monitor pops and compares them.
module tb_imem_loader;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          busy;
  logic          done;
  logic          err;
  logic          cpu_hold;
  logic [2:0]    dbg_state;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold), .dbg_state_o(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [37:0] exp_q[$];   // {addr, data} of each expected write
  logic [1:0]  res_q[$];   // {err, cpu_hold} expected when done rises
  logic [7:0]  stream_q[$];
  logic        done_prev = 1'b0;

  task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (wr_en) begin
      check("rx_ready_in_write", 38'(rx_ready), 38'd0);
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_write: got %h/%h expected none", wr_addr, wr_data);
      end else begin
        check("write", {wr_addr, wr_data}, exp_q.pop_front());
      end
    end
    if (done && !done_prev) begin
      check("busy_at_done", 38'(busy), 38'd0);
      if (res_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: got err=%0d expected no result", err);
      end else begin
        check("result", 38'({err, cpu_hold}), 38'(res_q.pop_front()));
      end
    end
    done_prev = done;
  end

  // reference model: interprets the byte list as LEN, 4*N data bytes, CSUM
  task automatic model(input int abort_at);
    int n;
    logic [7:0] x;
    logic e;
    n = int'(stream_q[0]);
    if (n == 0 || n > DEPTH) begin
      if (abort_at < 0) res_q.push_back(2'b11);
      return;
    end
    x = 8'h00;
    for (int w = 0; w < n; w++) begin
      if (abort_at < 0 || 4*w + 5 <= abort_at)
        exp_q.push_back({6'(w), stream_q[4*w+4], stream_q[4*w+3], stream_q[4*w+2], stream_q[4*w+1]});
    end
    for (int k = 1; k <= 4*n; k++) x ^= stream_q[k];
    e = (stream_q[4*n+1] != x);
    if (abort_at < 0) res_q.push_back({e, e});
  endtask

  // driver tasks (always entered and left at a negedge)
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int cnt;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    cnt = 0;
    while (!rx_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (!rx_ready) begin
      tests++; fails++;
      $display("FAIL rx_ready_timeout: got 0 expected 1");
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic run_session(input int gap_max, input int start_at, input int abort_at);
    int nb;
    int cnt;
    model(abort_at);
    pulse_start();
    nb = (abort_at >= 0) ? abort_at : stream_q.size();
    for (int i = 0; i < nb; i++) begin
      if (i == start_at) pulse_start();
      send_byte(stream_q[i], $urandom_range(0, gap_max));
    end
    if (abort_at >= 0) begin
      rst = 1'b1;
      #1;
      check("abort_hold", 38'(cpu_hold), 38'd1);
      check("abort_busy", 38'(busy), 38'd0);
      check("abort_rx_ready", 38'(rx_ready), 38'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      return;
    end
    cnt = 0;
    while (!done && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL done_timeout: got 0 expected 1");
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    logic [7:0] x;
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cpu_hold", 38'(cpu_hold), 38'd1);
    check("rst_rx_ready", 38'(rx_ready), 38'd0);
    check("rst_wr_en", 38'(wr_en), 38'd0);
    check("rst_busy", 38'(busy), 38'd0);
    check("rst_done", 38'(done), 38'd0);
    check("rst_err", 38'(err), 38'd0);
    check("rst_wr_port", {wr_addr, wr_data}, 38'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rx_valid = 1'($urandom_range(0, 1));
      rx_data  = 8'($urandom);
      @(negedge clk);
      check("idle_rx_ready", 38'(rx_ready), 38'd0);
    end
    rx_valid = 1'b0;

    stream_q = {8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    run_session(0, -1, -1);
    rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("done_rx_ready", 38'(rx_ready), 38'd0);
    rx_valid = 1'b0;

    stream_q = {8'h02, 8'h93, 8'h00, 8'h40, 8'h00, 8'h13, 8'h01, 8'h80, 8'h00, 8'h41};
    run_session(0, -1, -1);
    stream_q[9] = 8'h40;
    run_session(3, -1, -1);
    stream_q = {8'h00};
    run_session(0, -1, -1);
    stream_q = {8'h41};
    run_session(0, -1, -1);
    stream_q = {8'h02, 8'h93, 8'h00, 8'h40, 8'h00, 8'h13, 8'h01, 8'h80, 8'h00, 8'h41};
    run_session(1, 5, -1);

    stream_q = {8'd64};
    for (int w = 0; w < 64; w++) stream_q = {stream_q, 8'(w), 8'h00, 8'h00, 8'h00};
    stream_q.push_back(8'h00);
    run_session(1, -1, -1);
    run_session(0, -1, 23);
    stream_q = {8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    run_session(0, -1, -1);

    for (int s = 0; s < 6; s++) begin
      n = $urandom_range(1, 6);
      stream_q = {8'(n)};
      x = 8'h00;
      for (int k = 0; k < 4*n; k++) begin
        stream_q.push_back(8'($urandom));
        x ^= stream_q[k+1];
      end
      stream_q.push_back(($urandom_range(0, 1) == 1) ? x : (x ^ 8'($urandom_range(1, 255))));
      run_session(2, -1, -1);
    end
    stream_q = {8'($urandom_range(65, 255))};
    run_session(0, -1, -1);

    repeat (3) @(negedge clk);
    check("writes_drained", 38'(exp_q.size()), 38'd0);
    check("results_drained", 38'(res_q.size()), 38'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart to the 64 x 32-bit instruction memory.
- Receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and drives a single-cycle write port into the instruction memory.
- Checks an XOR checksum at the end of the stream and holds the CPU core in reset until a clean load completes.
- Sits between a byte source (UART RX / debug bridge) and the instruction memory write port.

Parameters:
- DEPTH, 64, number of instruction words in memory; addressable by a 6-bit word address.
- AW, 6, word-address width; log2(DEPTH).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a load session. Ignored while busy=1.
- rx_valid  in  1  byte source has a byte on rx_data.
- rx_data  in  8  incoming byte.
- rx_ready  out  1  loader accepts a byte this cycle. A handshake occurs when rx_valid and rx_ready are both high.
- wr_en  out  1  instruction memory write strobe, one cycle per word.
- wr_addr  out  AW  word address of the write.
- wr_data  out  32  instruction word to write.
- busy  out  1  session in progress (state is not IDLE or DONE).
- done  out  1  session finished; sticky until the next accepted start.
- err  out  1  session failed (bad length or checksum); sticky until the next accepted start.
- cpu_hold  out  1  holds the core in reset; high unless the last session finished with err=0.

Behaviour:
- Reset (async, immediate): state=IDLE; rx_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, cpu_hold=1. Internal word register, byte index, word count and XOR accumulator are cleared.
- Stream format, in order:
  - LEN byte N, valid range 1..64.
  - 4*N data bytes; the first byte of each word goes to [7:0], the fourth to [31:24].
  - One CSUM byte, equal to the XOR of all 4*N data bytes (the LEN byte is excluded).
- FSM states: IDLE, LEN, DATA, WRITE, CSUM, DONE.
  - IDLE: rx_ready=0. On start, go to LEN. Clear done, err, count, byte index and XOR. Set cpu_hold=1.
  - LEN: rx_ready=1. On handshake, latch N.
    - If rx_data==0 or rx_data>64: set err=1 and go to DONE. No write occurs.
    - Otherwise go to DATA.
  - DATA: rx_ready=1. On handshake, place the byte at byte index idx (0..3) of the word register and set XOR ^= rx_data.
    - idx==3: go to WRITE with idx reset to 0.
    - Otherwise idx++.
  - WRITE: rx_ready=0. wr_en=1 for exactly this cycle, with wr_addr=count[5:0] and wr_data=the assembled word; count++.
    - Go to CSUM if the incremented count==N, else back to DATA.
  - CSUM: rx_ready=1. On handshake, set err = (rx_data != XOR), then go to DONE.
  - DONE: done=1, busy=0, cpu_hold=err.
    - On start, go to LEN with the same clearing as in IDLE.
- Timing:
  - wr_en asserts the cycle after the 4th byte of a word is accepted.
  - Throughput is 1 byte/cycle with a one-cycle rx_ready bubble per word.
  - wr_addr and wr_data are held stable while wr_en=1; their values outside WRITE are don't-care but must not glitch wr_en.
- Width and range:
  - count is 7 bits so it can reach 64.
  - The address never exceeds DEPTH-1, and count never wraps within a session.
- Boundary conditions:
  - rx_valid gaps (rx_valid low) stall the FSM with no state change and no XOR update.
  - start is ignored in LEN, DATA, WRITE and CSUM.
  - An rx_valid pulse in IDLE or DONE is not accepted (rx_ready=0).
  - Reset mid-session returns to IDLE with cpu_hold=1. Words already written stay in memory; a partial word is discarded and never written.
  - On a checksum failure, all N writes have still occurred. err=1 and cpu_hold=1 mark the image as invalid.

Test Plan:
- Reset → cpu_hold=1, rx_ready=0, wr_en=0, busy=0, done=0, err=0. Toggling rx_valid in IDLE produces no writes.
- start; stream 01, 13,00,00,00, csum 13 → exactly one wr_en pulse with addr 0 and data 0x00000013; then done=1, err=0, cpu_hold=0, busy=0.
- start; stream 02, 93,00,40,00, 13,01,80,00, csum 41 → writes addr0=0x00400093 and addr1=0x00800113. rx_ready=0 during each WRITE cycle. done=1, err=0.
- Same stream as the previous case with csum 40, plus random rx_valid gaps → both writes still occur; done=1, err=1, cpu_hold=1.
- Bad LEN: byte 00, then a separate session with byte 41 → no wr_en; done=1, err=1 on each. A start pulse during an active session is ignored.
- N=64 with incrementing words → last write at addr 63 and no address wrap. Assert rst after 2 bytes of word 5 → IDLE immediately, no write for word 5, cpu_hold=1. A new start reloads from addr 0.
